// File: rtl/ms_uart_pkg.sv
// Shared definitions for the ms_uart 8N1 receiver (and a future transmitter).
package ms_uart_pkg;

   localparam int unsigned MIN_DIV    = 4;
   localparam int unsigned FRAME_BITS = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_t;

endpackage : ms_uart_pkg

// File: rtl/ms_sync_n.sv
// N-deep flop synchroniser for an asynchronous single-bit input.
module ms_sync_n #(
   parameter int unsigned SYNC_LEN = 2,
   parameter logic        RST_VAL  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_LEN-1:0] r_chain;

   // Shift the async input through the chain; the last flop is the clean copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= {SYNC_LEN{RST_VAL}};
      end else begin
         r_chain <= {r_chain[SYNC_LEN-2:0], i_d};
      end
   end

   assign o_q = r_chain[SYNC_LEN-1];

endmodule : ms_sync_n

// File: rtl/ms_uart_rx8n1.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
module ms_uart_rx8n1
   import ms_uart_pkg::*;
#(
   parameter int unsigned DIV_W    = 16,
   parameter int unsigned SYNC_LEN = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             rxd,
   output logic [7:0]       data,
   output logic             valid,
   input  logic             ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   logic              w_rxd_s;
   logic [DIV_W-1:0]  w_div_eff;
   logic [DIV_W-1:0]  w_half_end;
   logic [DIV_W-1:0]  w_bit_end;

   uart_state_t       r_state;
   logic              r_rxd_prev;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  r_cnt;
   logic [2:0]        r_bidx;
   logic [7:0]        r_shreg;
   logic              r_deliver;

   ms_sync_n #(
      .SYNC_LEN (SYNC_LEN),
      .RST_VAL  (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rxd),
      .o_q   (w_rxd_s)
   );

   // Clamp tiny divisors so the mid-bit point is always well defined.
   assign w_div_eff  = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
   assign w_half_end = (r_div >> 1) - DIV_W'(1);
   assign w_bit_end  = r_div - DIV_W'(1);

   // Previous synchronised line level for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxd_prev <= 1'b1;
      end else begin
         r_rxd_prev <= w_rxd_s;
      end
   end

   // Frame FSM: bit timing, sampling, shift register and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         busy      <= 1'b0;
         r_div     <= '0;
         r_cnt     <= '0;
         r_bidx    <= '0;
         r_shreg   <= '0;
         r_deliver <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_deliver <= 1'b0;
         frame_err <= 1'b0;
         if (!en) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_shreg <= '0;
         end else begin
            unique case (r_state)
               IDLE: begin
                  if (r_rxd_prev && !w_rxd_s) begin
                     r_state <= START;
                     busy    <= 1'b1;
                     r_cnt   <= '0;
                     r_div   <= w_div_eff;
                  end
               end
               START: begin
                  if (r_cnt == w_half_end) begin
                     if (w_rxd_s) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                     end else begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_bidx  <= '0;
                     end
                  end else begin
                     r_cnt <= r_cnt + DIV_W'(1);
                  end
               end
               DATA: begin
                  if (r_cnt == w_bit_end) begin
                     r_shreg <= {w_rxd_s, r_shreg[7:1]};
                     r_cnt   <= '0;
                     if (r_bidx == 3'(FRAME_BITS - 1)) begin
                        r_state <= STOP;
                     end else begin
                        r_bidx <= r_bidx + 3'd1;
                     end
                  end else begin
                     r_cnt <= r_cnt + DIV_W'(1);
                  end
               end
               STOP: begin
                  if (r_cnt == w_bit_end) begin
                     r_cnt <= '0;
                     if (w_rxd_s) begin
                        r_deliver <= 1'b1;
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                     end else begin
                        frame_err <= 1'b1;
                        r_state   <= BREAK;
                     end
                  end else begin
                     r_cnt <= r_cnt + DIV_W'(1);
                  end
               end
               BREAK: begin
                  if (w_rxd_s) begin
                     r_state <= IDLE;
                     busy    <= 1'b0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   // Holding register: a delivery beats a same-cycle read; a full, unread slot drops the byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data    <= 8'h00;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (r_deliver) begin
            if (!valid || ready) begin
               data  <= r_shreg;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule : ms_uart_rx8n1

// File: tb/tb_ms_uart_rx8n1.sv
// Directed bench for ms_uart_rx8n1: framed bytes, glitches, errors, overrun, reset.
`timescale 1ns/1ps
module tb_ms_uart_rx8n1;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] baud_div;
   logic        rxd;
   logic [7:0]  data;
   logic        valid;
   logic        ready;
   logic        busy;
   logic        frame_err;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   // Event counters maintained by the monitor only.
   int fe_cnt    = 0;
   int ov_cnt    = 0;
   int busy_cyc  = 0;
   int rise_cnt  = 0;
   logic       valid_q = 1'b0;
   logic [7:0] cap [0:31];

   int fe0, ov0, bz0, rs0;

   ms_uart_rx8n1 #(.DIV_W(16), .SYNC_LEN(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .baud_div  (baud_div),
      .rxd       (rxd),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   // Count pulses and capture each newly valid byte, sampled on the falling edge.
   always @(negedge clk) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if (busy)      busy_cyc <= busy_cyc + 1;
      if (valid && !valid_q) begin
         cap[rise_cnt[4:0]] <= data;
         rise_cnt <= rise_cnt + 1;
      end
      valid_q <= valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drive one LSB-first frame; rxd is left at the stop level afterwards.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int div);
      rxd = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (div) @(negedge clk);
      end
      rxd = stop_v;
      repeat (div) @(negedge clk);
   endtask

   task automatic snap();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      bz0 = busy_cyc;
      rs0 = rise_cnt;
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b1;
      ready    = 1'b0;
      rxd      = 1'b1;
      baud_div = 16'd174;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_ovr", 32'(overrun), 32'h0);
      rst_n = 1'b1;

      // 1. 115200 baud frame 0x75 after ~55.9 us idle
      snap();
      idle(1118);
      send_frame(8'h75, 1'b1, 174);
      idle(4);
      chk("t1_valid", 32'(valid), 32'h1);
      chk("t1_data", 32'(data), 32'h75);
      chk("t1_ferr", 32'(fe_cnt - fe0), 32'h0);
      chk("t1_ovr", 32'(ov_cnt - ov0), 32'h0);
      chk("t1_busy", 32'(busy), 32'h0);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("t1_consumed", 32'(valid), 32'h0);

      // 2. Short low glitch is rejected at mid start bit
      baud_div = 16'd16;
      idle(20);
      snap();
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      idle(30);
      chk("t2_busy_seen", 32'(busy_cyc != bz0), 32'h1);
      chk("t2_busy_idle", 32'(busy), 32'h0);
      chk("t2_no_valid", 32'(rise_cnt - rs0), 32'h0);
      chk("t2_no_ferr", 32'(fe_cnt - fe0), 32'h0);

      // 3. Framing error then break, followed by a good frame
      snap();
      send_frame(8'hC3, 1'b0, 16);
      repeat (16) @(negedge clk);
      idle(20);
      chk("t3_ferr", 32'(fe_cnt - fe0), 32'h1);
      chk("t3_no_valid", 32'(valid), 32'h0);
      chk("t3_busy", 32'(busy), 32'h0);
      send_frame(8'h5A, 1'b1, 16);
      idle(4);
      chk("t3_valid", 32'(valid), 32'h1);
      chk("t3_data", 32'(data), 32'h5A);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;

      // 4. Overrun while the slot is full
      idle(10);
      snap();
      send_frame(8'hA5, 1'b1, 16);
      idle(10);
      chk("t4_first", 32'(data), 32'hA5);
      send_frame(8'h11, 1'b1, 16);
      idle(4);
      chk("t4_ovr", 32'(ov_cnt - ov0), 32'h1);
      chk("t4_held_data", 32'(data), 32'hA5);
      chk("t4_held_valid", 32'(valid), 32'h1);
      ready = 1'b1;
      @(negedge clk);
      chk("t4_drop_valid", 32'(valid), 32'h0);
      chk("t4_data_kept", 32'(data), 32'hA5);

      // 5. Back-to-back frames with ready held high
      idle(10);
      snap();
      send_frame(8'h00, 1'b1, 16);
      send_frame(8'hFF, 1'b1, 16);
      idle(8);
      chk("t5_count", 32'(rise_cnt - rs0), 32'h2);
      chk("t5_byte0", 32'(cap[rs0[4:0]]), 32'h00);
      chk("t5_byte1", 32'(cap[5'(rs0 + 1)]), 32'hFF);
      chk("t5_ovr", 32'(ov_cnt - ov0), 32'h0);

      // Divisor below the minimum runs at 4 clocks per bit
      baud_div = 16'd2;
      idle(10);
      snap();
      send_frame(8'h96, 1'b1, 4);
      idle(6);
      chk("div_min_count", 32'(rise_cnt - rs0), 32'h1);
      chk("div_min_byte", 32'(cap[rs0[4:0]]), 32'h96);

      // Disabling the receiver mid-frame aborts it
      baud_div = 16'd16;
      idle(10);
      snap();
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      chk("en_busy_before", 32'(busy), 32'h1);
      en = 1'b0;
      @(negedge clk);
      chk("en_abort", 32'(busy), 32'h0);
      idle(20);
      en = 1'b1;
      idle(200);
      chk("en_no_valid", 32'(rise_cnt - rs0), 32'h0);

      // 6. Async reset in the middle of 0x81, then a clean frame
      snap();
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (16) @(negedge clk);
      rxd = 1'b0;
      repeat (32) @(negedge clk);
      rst_n = 1'b0;
      rxd   = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_valid", 32'(valid), 32'h0);
      chk("t6_rst_data", 32'(data), 32'h00);
      rst_n = 1'b1;
      idle(40);
      snap();
      send_frame(8'h3C, 1'b1, 16);
      idle(4);
      chk("t6_count", 32'(rise_cnt - rs0), 32'h1);
      chk("t6_data", 32'(cap[rs0[4:0]]), 32'h3C);
      chk("t6_ferr", 32'(fe_cnt - fe0), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ms_uart_rx8n1
